// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA 640x480 sync receiver: position recovery, timing check, lock (stats: VGA_SYNC_STATS_EN)
module vga_sync_monitor #(
  parameter int H_DISPLAY    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC       = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_DISPLAY    = 480,
  parameter int V_SYNC_START = 513,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clock_at_100mhz,
  input  logic        reset_button,
  input  logic        p_tick,
  input  logic        horizontal_sync,
  input  logic        vertical_sync,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        video_on,
  output logic        locked,
  output logic        sync_error,
  output logic        no_signal,
  output logic [10:0] h_period,
  output logic [10:0] hsync_width,
  output logic [9:0]  v_period,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);

  localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0]   CNT_MAX   = 11'h7FF;
  localparam logic [9:0]    LINE_MAX  = 10'h3FF;
  localparam logic [10:0]   H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0]   H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0]   WD_LAST   = 11'(2 * H_TOTAL - 1);
  localparam logic [9:0]    X_START   = 10'(H_SYNC_START);
  localparam logic [9:0]    X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    X_VIS     = 10'(H_DISPLAY);
  localparam logic [9:0]    Y_START   = 10'(V_SYNC_START);
  localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    Y_VIS     = 10'(V_DISPLAY);
  localparam logic [9:0]    V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_N    = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_nxt;
  logic [GW-1:0] good_inc;
  logic          err_now;

  logic          hs_s;
  logic          vs_s;
  logic [10:0]   tick_cnt;
  logic [10:0]   wid_cnt;
  logic [9:0]    line_cnt;
  logic          armed;
  logic          frame_ok;

  logic          hs_rise;
  logic          hs_fall;
  logic          vs_rise;
  logic [10:0]   hp_meas;
  logic [9:0]    lines_meas;
  logic          line_bad;
  logic          frame_good;
  logic          wd_fire;
  logic          enter_search;
  logic          x_wrap;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          locked_nxt;

  // Edge detection compares the live sync level against the sample taken on the previous tick.
  assign hs_rise  = p_tick & horizontal_sync & ~hs_s;
  assign hs_fall  = p_tick & ~horizontal_sync & hs_s;
  assign vs_rise  = p_tick & vertical_sync & ~vs_s;

  // The line period being closed by this rise, saturating with the counter.
  assign hp_meas    = (tick_cnt == CNT_MAX) ? CNT_MAX : tick_cnt + 11'd1;
  // A rise coinciding with the vsync rise is credited to the frame that is ending.
  assign lines_meas = (hs_rise && line_cnt != LINE_MAX) ? line_cnt + 10'd1 : line_cnt;

  // The first rise after a (re)start carries a meaningless period, so it is only used to arm checking.
  assign line_bad   = hs_rise & armed & ((hp_meas != H_TOTAL_W) | (hsync_width != H_SYNC_W));
  assign frame_good = frame_ok & ~line_bad & (lines_meas == V_TOTAL_W);
  assign wd_fire    = p_tick & ~hs_rise & (tick_cnt == WD_LAST);

  assign good_inc     = good_cnt + GW'(1);
  assign enter_search = (state != ST_SEARCH) && (state_nxt == ST_SEARCH);
  assign locked_nxt   = (state_nxt == ST_LOCKED);

  // Lock state register.
  always_ff @(posedge clock_at_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Lock next-state: judge frames at vsync rises, drop lock on any bad line/frame or lost hsync.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_now   = 1'b0;
    case (state)
      ST_SEARCH: begin
        good_nxt = '0;
        if (vs_rise) begin
          state_nxt = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (vs_rise) begin
          if (frame_good) begin
            good_nxt = good_inc;
            if (good_inc >= LOCK_N) begin
              state_nxt = ST_LOCKED;
            end
          end else begin
            good_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad || (vs_rise && !frame_good)) begin
          err_now   = 1'b1;
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        good_nxt  = '0;
      end
    endcase
    if (wd_fire) begin
      state_nxt = ST_SEARCH;
      good_nxt  = '0;
      if (state == ST_LOCKED) begin
        err_now = 1'b1;
      end
    end
  end

  // Recovered position: hsync rise and vsync rise re-anchor the counters; vsync load beats the line wrap.
  always_comb begin
    x_nxt  = x_pixel;
    y_nxt  = y_pixel;
    x_wrap = 1'b0;
    if (p_tick) begin
      if (hs_rise) begin
        x_nxt = X_START;
      end else if (x_pixel == X_LAST) begin
        x_nxt  = '0;
        x_wrap = 1'b1;
      end else begin
        x_nxt = x_pixel + 10'd1;
      end
      if (vs_rise) begin
        y_nxt = Y_START;
      end else if (x_wrap) begin
        y_nxt = (y_pixel == Y_LAST) ? 10'd0 : y_pixel + 10'd1;
      end
    end
  end

  // Timing measurement, watchdog and registered status outputs.
  always_ff @(posedge clock_at_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      hs_s        <= 1'b0;
      vs_s        <= 1'b0;
      tick_cnt    <= '0;
      wid_cnt     <= '0;
      line_cnt    <= '0;
      armed       <= 1'b0;
      frame_ok    <= 1'b0;
      h_period    <= '0;
      hsync_width <= '0;
      v_period    <= '0;
      no_signal   <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      locked      <= 1'b0;
      video_on    <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      if (p_tick) begin
        hs_s <= horizontal_sync;
        vs_s <= vertical_sync;

        if (hs_rise) begin
          tick_cnt <= '0;
        end else if (tick_cnt != CNT_MAX) begin
          tick_cnt <= tick_cnt + 11'd1;
        end

        if (hs_rise) begin
          wid_cnt <= 11'd1;
        end else if (horizontal_sync && wid_cnt != CNT_MAX) begin
          wid_cnt <= wid_cnt + 11'd1;
        end

        if (hs_fall) begin
          hsync_width <= wid_cnt;
        end
        if (hs_rise) begin
          h_period <= hp_meas;
        end

        if (vs_rise) begin
          v_period <= lines_meas;
          line_cnt <= '0;
        end else begin
          line_cnt <= lines_meas;
        end

        if (hs_rise) begin
          no_signal <= 1'b0;
        end else if (wd_fire) begin
          no_signal <= 1'b1;
        end

        if (vs_rise) begin
          frame_ok <= 1'b1;
        end else if (line_bad) begin
          frame_ok <= 1'b0;
        end

        if (wd_fire || enter_search) begin
          armed <= 1'b0;
        end else if (hs_rise) begin
          armed <= 1'b1;
        end
      end

      x_pixel    <= x_nxt;
      y_pixel    <= y_nxt;
      locked     <= locked_nxt;
      video_on   <= locked_nxt && (x_nxt < X_VIS) && (y_nxt < Y_VIS);
      sync_error <= err_now;
    end
  end

`ifdef VGA_SYNC_STATS_EN
  // Saturating frame and error event counters, cleared only by reset.
  always_ff @(posedge clock_at_100mhz or negedge reset_button) begin
    if (!reset_button) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (vs_rise && frame_count != 16'hFFFF) begin
        frame_count <= frame_count + 16'd1;
      end
      if (err_now && error_count != 16'hFFFF) begin
        error_count <= error_count + 16'd1;
      end
    end
  end
`else
  assign frame_count = 16'd0;
  assign error_count = 16'd0;
`endif

endmodule
